// File: rtl/decode_stage.sv
// RV32I decode stage: instruction FIFO feeding a registered, handshaked control bundle.
// Optional M-extension decode; illegal encodings are flagged and emitted with enables cleared.
module decode_stage #(
    parameter int unsigned INST_WIDTH   = 32,
    parameter int unsigned NUM_REGISTER = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned ENABLE_M     = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            i_inst_valid,
    output logic                            o_inst_ready,
    input  logic [INST_WIDTH-1:0]           i_inst,
    input  logic [31:0]                     i_pc,
    output logic                            o_dec_valid,
    input  logic                            i_dec_ready,
    output logic [31:0]                     o_pc,
    output logic [6:0]                      o_opcode,
    output logic [$clog2(NUM_REGISTER)-1:0] o_rs1_addr,
    output logic [$clog2(NUM_REGISTER)-1:0] o_rs2_addr,
    output logic [$clog2(NUM_REGISTER)-1:0] o_rd_addr,
    output logic [5:0]                      o_alu_op,
    output logic                            o_alu_src_a,
    output logic                            o_alu_src_b,
    output logic [1:0]                      o_result_mux,
    output logic                            o_branch,
    output logic [2:0]                      o_branch_op,
    output logic                            o_mem_write,
    output logic                            o_reg_write,
    output logic                            o_illegal,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count
);

    localparam int unsigned RW = $clog2(NUM_REGISTER);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_SLL  = 6'd2;
    localparam logic [5:0] ALU_SLT  = 6'd3;
    localparam logic [5:0] ALU_SLTU = 6'd4;
    localparam logic [5:0] ALU_XOR  = 6'd5;
    localparam logic [5:0] ALU_SRL  = 6'd6;
    localparam logic [5:0] ALU_SRA  = 6'd7;
    localparam logic [5:0] ALU_OR   = 6'd8;
    localparam logic [5:0] ALU_AND  = 6'd9;
    localparam logic [5:0] ALU_MUL  = 6'd10;  // MUL..REMU follow in funct3 order

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_PC4  = 2'b01;
    localparam logic [1:0] RES_MEM  = 2'b10;
    localparam logic [2:0] BR_JUMP  = 3'b010;

    function automatic logic [5:0] base_op(input logic [2:0] f3);
        logic [5:0] op;
        unique case (f3)
            3'b000: op = ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];
    logic [31:0]           pc_mem   [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, load;

    assign o_inst_ready = !i_rst && (count_q != CW'(FIFO_DEPTH));
    assign push         = i_inst_valid && o_inst_ready;
    assign load         = (count_q != '0) && (!o_dec_valid || i_dec_ready);
    assign o_fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !load) begin
            count_d = count_q + CW'(1);
        end else if (!push && load) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (load) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            inst_mem[wr_ptr_q] <= i_inst;
            pc_mem[wr_ptr_q]   <= i_pc;
        end
    end

    logic [INST_WIDTH-1:0] head;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [RW-1:0]         dec_rs1;
    logic [5:0]            dec_alu_op;
    logic                  dec_src_a, dec_src_b, dec_branch;
    logic                  dec_mem_write, dec_reg_write, dec_illegal;
    logic [1:0]            dec_result;
    logic [2:0]            dec_branch_op;

    assign head   = inst_mem[rd_ptr_q];
    assign opcode = head[6:0];
    assign funct3 = head[14:12];
    assign funct7 = head[31:25];

    // Every listed opcode ends in 2'b11, so inst[1:0] != 11 falls into the default.
    always_comb begin
        dec_rs1       = head[15 +: RW];
        dec_alu_op    = ALU_ADD;
        dec_src_a     = 1'b0;
        dec_src_b     = 1'b0;
        dec_result    = RES_ALU;
        dec_branch    = 1'b0;
        dec_branch_op = 3'b000;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_illegal   = 1'b0;
        unique case (opcode)
            OP_ALU: begin
                dec_reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec_alu_op = base_op(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_alu_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_alu_op = ALU_SRA;
                end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    dec_alu_op = ALU_MUL + 6'(funct3);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_ALUI: begin
                dec_src_b     = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = base_op(funct3);
                if (funct3 == 3'b001 && funct7 != 7'b0000000) dec_illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000) dec_alu_op = ALU_SRA;
                    else if (funct7 != 7'b0000000) dec_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                dec_rs1       = '0;
                dec_src_b     = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec_src_a     = 1'b1;
                dec_src_b     = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                dec_src_a     = (opcode == OP_JAL);
                dec_src_b     = 1'b1;
                dec_result    = RES_PC4;
                dec_branch    = 1'b1;
                dec_branch_op = BR_JUMP;
                dec_reg_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_src_a     = 1'b1;
                dec_src_b     = 1'b1;
                dec_branch    = 1'b1;
                dec_branch_op = funct3;
                if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
            end
            OP_LOAD: begin
                dec_src_b     = 1'b1;
                dec_result    = RES_MEM;
                dec_reg_write = 1'b1;
                if (funct3 != 3'b010) dec_illegal = 1'b1;
            end
            OP_STORE: begin
                dec_src_b     = 1'b1;
                dec_mem_write = 1'b1;
                if (funct3 != 3'b010) dec_illegal = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal instructions carry only their fields and PC; all control is cleared.
        if (dec_illegal) begin
            dec_alu_op    = ALU_ADD;
            dec_src_a     = 1'b0;
            dec_src_b     = 1'b0;
            dec_result    = RES_ALU;
            dec_branch    = 1'b0;
            dec_branch_op = 3'b000;
            dec_mem_write = 1'b0;
            dec_reg_write = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dec_valid  <= 1'b0;
            o_pc         <= '0;
            o_opcode     <= '0;
            o_rs1_addr   <= '0;
            o_rs2_addr   <= '0;
            o_rd_addr    <= '0;
            o_alu_op     <= '0;
            o_alu_src_a  <= 1'b0;
            o_alu_src_b  <= 1'b0;
            o_result_mux <= '0;
            o_branch     <= 1'b0;
            o_branch_op  <= '0;
            o_mem_write  <= 1'b0;
            o_reg_write  <= 1'b0;
            o_illegal    <= 1'b0;
        end else if (i_flush) begin
            o_dec_valid <= 1'b0;
        end else if (load) begin
            o_dec_valid  <= 1'b1;
            o_pc         <= pc_mem[rd_ptr_q];
            o_opcode     <= opcode;
            o_rs1_addr   <= dec_rs1;
            o_rs2_addr   <= head[20 +: RW];
            o_rd_addr    <= head[7 +: RW];
            o_alu_op     <= dec_alu_op;
            o_alu_src_a  <= dec_src_a;
            o_alu_src_b  <= dec_src_b;
            o_result_mux <= dec_result;
            o_branch     <= dec_branch;
            o_branch_op  <= dec_branch_op;
            o_mem_write  <= dec_mem_write;
            o_reg_write  <= dec_reg_write;
            o_illegal    <= dec_illegal;
        end else if (o_dec_valid && i_dec_ready) begin
            o_dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (ENABLE_M=0 and 1) share stimulus and are
// compared each cycle against a queue-based FIFO model and a rule-level decoder.
module tb_decode_stage;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  alu_op;
        logic        src_a;
        logic        src_b;
        logic [1:0]  res;
        logic        branch;
        logic [2:0]  bop;
        logic        mem_write;
        logic        reg_write;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst, flush, inst_valid, dec_ready;
    logic [31:0] inst, pc;

    logic        inst_ready [2];
    logic        dec_valid  [2];
    logic [31:0] o_pc       [2];
    logic [6:0]  opcode     [2];
    logic [4:0]  rs1_addr   [2];
    logic [4:0]  rs2_addr   [2];
    logic [4:0]  rd_addr    [2];
    logic [5:0]  alu_op     [2];
    logic        alu_src_a  [2];
    logic        alu_src_b  [2];
    logic [1:0]  result_mux [2];
    logic        branch     [2];
    logic [2:0]  branch_op  [2];
    logic        mem_write  [2];
    logic        reg_write  [2];
    logic        illegal    [2];
    logic [2:0]  fifo_count [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_stage #(
            .INST_WIDTH  (32),
            .NUM_REGISTER(32),
            .FIFO_DEPTH  (DEPTH),
            .ENABLE_M    (g)
        ) dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_flush     (flush),
            .i_inst_valid(inst_valid),
            .o_inst_ready(inst_ready[g]),
            .i_inst      (inst),
            .i_pc        (pc),
            .o_dec_valid (dec_valid[g]),
            .i_dec_ready (dec_ready),
            .o_pc        (o_pc[g]),
            .o_opcode    (opcode[g]),
            .o_rs1_addr  (rs1_addr[g]),
            .o_rs2_addr  (rs2_addr[g]),
            .o_rd_addr   (rd_addr[g]),
            .o_alu_op    (alu_op[g]),
            .o_alu_src_a (alu_src_a[g]),
            .o_alu_src_b (alu_src_b[g]),
            .o_result_mux(result_mux[g]),
            .o_branch    (branch[g]),
            .o_branch_op (branch_op[g]),
            .o_mem_write (mem_write[g]),
            .o_reg_write (reg_write[g]),
            .o_illegal   (illegal[g]),
            .o_fifo_count(fifo_count[g])
        );
    end

    // Reference model state
    entry_t  q[$];
    entry_t  stage;
    bit      m_valid = 1'b0;

    // ALU encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9,
    // then MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU as 10..17.
    logic [5:0] by_funct3 [8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9};

    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] p,
                                           input int m_en);
        bundle_t    b;
        logic [6:0] opc = w[6:0];
        logic [2:0] f3  = w[14:12];
        logic [6:0] f7  = w[31:25];
        bit         bad = 1'b0;
        b        = '0;
        b.opcode = opc;
        b.rs1    = w[19:15];
        b.rs2    = w[24:20];
        b.rd     = w[11:7];
        b.pc     = p;
        case (opc)
            7'h33: begin
                b.reg_write = 1'b1;
                if (f7 == 7'h00) b.alu_op = by_funct3[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) b.alu_op = 6'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) b.alu_op = 6'd7;
                else if (f7 == 7'h01 && m_en == 1) b.alu_op = 6'd10 + {3'd0, f3};
                else bad = 1'b1;
            end
            7'h13: begin
                b.src_b = 1'b1; b.reg_write = 1'b1;
                b.alu_op = by_funct3[f3];
                if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
                if (f3 == 3'd5 && f7 == 7'h20) b.alu_op = 6'd7;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
            end
            7'h37: begin b.rs1 = 5'd0; b.src_b = 1'b1; b.reg_write = 1'b1; end
            7'h17: begin b.src_a = 1'b1; b.src_b = 1'b1; b.reg_write = 1'b1; end
            7'h6f, 7'h67: begin
                b.src_a = (opc == 7'h6f); b.src_b = 1'b1; b.res = 2'b01;
                b.branch = 1'b1; b.bop = 3'b010; b.reg_write = 1'b1;
            end
            7'h63: begin
                b.src_a = 1'b1; b.src_b = 1'b1; b.branch = 1'b1; b.bop = f3;
                bad = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h03: begin b.src_b = 1'b1; b.res = 2'b10; b.reg_write = 1'b1; bad = (f3 != 3'd2); end
            7'h23: begin b.src_b = 1'b1; b.mem_write = 1'b1; bad = (f3 != 3'd2); end
            7'h0f, 7'h73: ;
            default: bad = 1'b1;
        endcase
        if (bad) begin
            b.alu_op = '0; b.src_a = 0; b.src_b = 0; b.res = '0; b.branch = 0;
            b.bop = '0; b.mem_write = 0; b.reg_write = 0; b.illegal = 1'b1;
        end
        return b;
    endfunction

    function automatic bundle_t observed(input int g);
        bundle_t b;
        b.opcode = opcode[g];     b.rs1 = rs1_addr[g];    b.rs2 = rs2_addr[g];
        b.rd = rd_addr[g];        b.alu_op = alu_op[g];   b.src_a = alu_src_a[g];
        b.src_b = alu_src_b[g];   b.res = result_mux[g];  b.branch = branch[g];
        b.bop = branch_op[g];     b.mem_write = mem_write[g];
        b.reg_write = reg_write[g]; b.illegal = illegal[g]; b.pc = o_pc[g];
        return b;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("inst_ready[m%0d]", g), 128'(inst_ready[g]), 128'(q.size() < DEPTH));
            check($sformatf("fifo_count[m%0d]", g), 128'(fifo_count[g]), 128'(q.size()));
            check($sformatf("dec_valid[m%0d]", g), 128'(dec_valid[g]), 128'(m_valid));
            if (m_valid)
                check($sformatf("bundle[m%0d] inst %h", g, stage.inst),
                      128'(observed(g)), 128'(ref_decode(stage.inst, stage.pc, g)));
        end
    endtask

    task automatic model_edge(input bit v, input logic [31:0] w, input logic [31:0] p,
                              input bit rdy, input bit fl);
        bit can_push;
        can_push = (q.size() < DEPTH);
        if (fl) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            if (q.size() > 0 && (!m_valid || rdy)) begin
                stage   = q.pop_front();
                m_valid = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (v && can_push) q.push_back('{inst: w, pc: p});
        end
    endtask

    // Drive one cycle's inputs, check the current state, then advance past the edge.
    task automatic step(input bit v, input logic [31:0] w, input logic [31:0] p,
                        input bit rdy, input bit fl);
        inst_valid = v; inst = w; pc = p; dec_ready = rdy; flush = fl;
        #1;
        compare_all();
        model_edge(v, w, p, rdy, fl);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67,
                                  7'h63, 7'h03, 7'h23, 7'h0f, 7'h73, 7'h7f};
        logic [31:0] w   = $urandom;
        int          sel = $urandom_range(0, 12);
        if (sel < 12) w[6:0] = ops[sel];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if ((w[6:0] == 7'h03 || w[6:0] == 7'h23) && $urandom_range(0, 1) == 1) w[14:12] = 3'b010;
        return w;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; inst_valid = 1'b0; dec_ready = 1'b0;
        inst = '0; pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset inst_ready", 128'(inst_ready[0]), 128'(0));
        check("reset fifo_count", 128'(fifo_count[0]), 128'(0));
        check("reset dec_valid", 128'(dec_valid[1]), 128'(0));
        check("reset bundle m0", 128'(observed(0)), 128'(0));
        check("reset bundle m1", 128'(observed(1)), 128'(0));
        rst = 1'b0;
        #1;
        check("inst_ready after reset", 128'(inst_ready[0]), 128'(1));

        // ADD x3,x1,x2 presented after two edges
        step(1, 32'h002081B3, 32'h100, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        check("add valid", 128'(dec_valid[0]), 128'(1));
        check("add rd", 128'(rd_addr[0]), 128'(3));
        check("add alu_op", 128'(alu_op[0]), 128'(0));
        check("add reg_write", 128'(reg_write[0]), 128'(1));
        check("add pc", 128'(o_pc[0]), 128'(32'h100));
        step(0, 32'h0, 32'h0, 1, 0);

        // Stall: five pushes fill the output register plus the FIFO
        for (int i = 0; i < 5; i++)
            step(1, 32'h00000013 | (32'(i + 1) << 7), 32'h200 + 32'(4 * i), 0, 0);
        check("full count", 128'(fifo_count[0]), 128'(4));
        check("full ready", 128'(inst_ready[0]), 128'(0));
        step(1, 32'h00A00093, 32'h2FC, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 32'h0, 32'h0, 1, 0);

        // MUL x1,x2,x3 on both builds
        step(1, 32'h023100B3, 32'h300, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        check("mul alu_op m1", 128'(alu_op[1]), 128'(10));
        check("mul illegal m0", 128'(illegal[0]), 128'(1));
        check("mul reg_write m0", 128'(reg_write[0]), 128'(0));

        // Unknown opcode, then BEQ with funct3=010
        step(1, 32'h0000007F, 32'h400, 1, 0);
        step(1, 32'h0020A063, 32'h404, 1, 0);
        check("op7f illegal", 128'(illegal[0]), 128'(1));
        check("op7f reg_write", 128'(reg_write[0]), 128'(0));
        step(0, 32'h0, 32'h0, 1, 0);
        check("beq010 illegal", 128'(illegal[1]), 128'(1));
        check("beq010 branch", 128'(branch[1]), 128'(0));
        step(0, 32'h0, 32'h0, 1, 0);

        // Flush while stalled with three FIFO entries and an offered instruction
        for (int i = 0; i < 4; i++) step(1, 32'h00000033, 32'h500 + 32'(4 * i), 0, 0);
        check("pre-flush count", 128'(fifo_count[0]), 128'(3));
        step(1, 32'h002081B3, 32'h510, 0, 1);
        check("flush count", 128'(fifo_count[0]), 128'(0));
        check("flush valid", 128'(dec_valid[0]), 128'(0));
        step(0, 32'h0, 32'h0, 1, 0);

        // LUI x5,0x12345
        step(1, 32'h123452B7, 32'h600, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        check("lui rs1", 128'(rs1_addr[0]), 128'(0));
        check("lui src_b", 128'(alu_src_b[0]), 128'(1));
        check("lui reg_write", 128'(reg_write[0]), 128'(1));

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0);
        step(0, 32'h0, 32'h0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined instruction decode stage for the RV32I core, generalising the combinational decoder.
- Buffers fetched instructions in a FIFO and decodes the FIFO head into the same control bundle the datapath uses today.
- Registers the decoded bundle behind a valid/ready handshake, so fetch and execute can stall independently.
- Adds a pipeline flush, illegal-instruction detection and optional M-extension decode.

Parameters:
- INST_WIDTH, 32, instruction width in bits.
- NUM_REGISTER, 32, register file size; register address width is clog2(NUM_REGISTER).
- FIFO_DEPTH, 4, instruction buffer entries; must be a power of two, ≥2.
- ENABLE_M, 0, 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU using the OP_ALU_MUL..OP_ALU_REMU encodings added to definitions.vh.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_flush  in  1  discard all buffered and staged instructions.
- i_inst_valid  in  1  fetch offers an instruction.
- o_inst_ready  out  1  FIFO can accept an instruction.
- i_inst  in  INST_WIDTH  instruction word.
- i_pc  in  32  PC of i_inst.
- o_dec_valid  out  1  decoded bundle valid.
- i_dec_ready  in  1  execute accepts the bundle.
- o_pc  out  32  PC of the decoded instruction.
- o_opcode  out  7  instruction opcode.
- o_rs1_addr, o_rs2_addr, o_rd_addr  out  clog2(NUM_REGISTER) each  register addresses.
- o_alu_op  out  6  ALU operation.
- o_alu_src_a  out  1  0 = REG_A, 1 = PC.
- o_alu_src_b  out  1  0 = REG_B, 1 = IMME.
- o_result_mux  out  2  00 = ALU, 01 = PC+4, 10 = DATA_MEM.
- o_branch  out  1  branch or jump.
- o_branch_op  out  3  branch condition.
- o_mem_write  out  1  store.
- o_reg_write  out  1  register write enable.
- o_illegal  out  1  instruction is illegal.
- o_fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset:
  - FIFO pointers and count are 0.
  - o_dec_valid and all bundle outputs are 0.
  - o_inst_ready is 0 while i_rst is high and 1 in the first cycle after reset.
- Push: i_inst_valid && o_inst_ready at a rising edge writes {i_inst, i_pc} at the write pointer.
- o_inst_ready = (count < FIFO_DEPTH). A push is never accepted when the FIFO is full, even if a pop occurs in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leave count unchanged.
- Output register loads the decoded FIFO head when the FIFO is non-empty and (!o_dec_valid || i_dec_ready); that load is the pop.
- When o_dec_valid && i_dec_ready and the FIFO is empty, o_dec_valid clears.
- While o_dec_valid && !i_dec_ready, all outputs hold stable.
- Latency: an instruction pushed at edge N is presented with o_dec_valid=1 after edge N+1, provided the FIFO and output register were empty.
- Throughput: 1 instruction per cycle.
- Flush: i_flush at an edge empties the FIFO and clears o_dec_valid. Flush has priority over push, pop and load, so an offered instruction is dropped. Flush takes effect during a stall.
- Decode rules:
  - rs1 is forced to 0 for LUI. Other field extraction, the control bundle per opcode and the defaults are unchanged from the current decoder.
  - OP_ALU: funct7 must be 0000000, or 0100000 only with funct3 000/101.
  - OP_ALU with funct7 0000001 decodes as an M operation when ENABLE_M=1 and is illegal otherwise.
  - OP_ALUI with funct3 001 requires funct7 0000000; with funct3 101 it requires funct7 0000000 or 0100000.
  - OP_BRANCH with funct3 010 or 011 is illegal.
  - OP_LOAD and OP_STORE require funct3 010.
  - FENCE and SYSTEM are legal no-ops: all enables are 0.
  - Any other opcode, or inst[1:0] != 11, is illegal.
- Illegal instruction:
  - Sets o_illegal=1 and forces o_reg_write=0, o_mem_write=0, o_branch=0.
  - Still emitted with its PC.

Test Plan:
- Reset, then push ADD x3,x1,x2 (0x002081B3), PC=0x100, with i_dec_ready=1 → o_dec_valid=1 after 2 edges, o_rd_addr=3, o_alu_op=OP_ALU_ADD, o_reg_write=1, o_pc=0x100.
- Hold i_dec_ready=0 and push 5 instructions with FIFO_DEPTH=4 → after 4 accepts, o_inst_ready=0 and o_fifo_count=4. One more enters the output register. Outputs stay stable; release drains all 5 in order, one per cycle.
- Push MUL x1,x2,x3 (0x023100B3) → with ENABLE_M=1, o_alu_op=OP_ALU_MUL. With ENABLE_M=0, o_illegal=1 and o_reg_write=0.
- Push opcode 0x7F and a BEQ with funct3=010 → both emitted with o_illegal=1 and all enables 0.
- Fill the FIFO with 3 entries while stalled, then assert i_flush together with i_inst_valid → next cycle o_fifo_count=0, o_dec_valid=0, and the offered instruction is not accepted.
- Push LUI x5,0x12345 (0x123452B7) → o_rs1_addr=0, o_alu_src_b=1, o_reg_write=1.
